// File: rtl/conv_kxk_param.sv
// K x K streaming convolution: column-fed window, registered multipliers,
// pipelined binary adder tree and a round/shift/saturate output stage.
// Coefficients live in a shadow bank that is copied to the active bank only
// once the multiplier/adder stages hold no valid sample.
module conv_kxk_param #(
    parameter int K     = 3,
    parameter int DW    = 8,
    parameter int CW    = 16,
    parameter int SHIFT = 0
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    i_valid,
    input  logic                                    i_done,
    input  logic [K*DW-1:0]                         i_data,
    input  logic                                    coef_we,
    input  logic [$clog2(K*K)-1:0]                  coef_addr,
    input  logic signed [CW-1:0]                    coef_data,
    input  logic                                    coef_commit,
    output logic                                    coef_pending,
    output logic                                    o_valid,
    output logic                                    o_img_done,
    output logic signed [DW+CW+1+$clog2(K*K)-1:0]   o_data,
    output logic [DW-1:0]                           o_pix
);

    localparam int NT   = K * K;
    localparam int LG   = $clog2(NT);
    localparam int PW   = DW + CW + 1;
    localparam int AW   = PW + LG;
    localparam int LAT  = 3 + LG;
    localparam int CT   = ((K - 1) / 2) * K + (K - 1) / 2;
    localparam int HALF = (NT + 1) / 2;

    // Identity tap value: unity gain once the output shift is applied.
    localparam logic signed [CW-1:0] C_ID = CW'(1) << SHIFT;
    localparam logic signed [AW:0]   BIAS = (SHIFT > 0) ? ((AW+1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [AW:0]   PMAX = {{(AW+1-DW){1'b0}}, {DW{1'b1}}};

    // Operand count present at a given adder-tree level.
    function automatic int lvl_cnt(input int l);
        int n;
        n = NT;
        for (int i = 0; i < l; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // Round half-up at the shift point, arithmetic shift, clamp to [0, 2^DW-1].
    function automatic logic [DW-1:0] round_sat(input logic signed [AW-1:0] s);
        logic signed [AW:0] t;
        t = ($signed({s[AW-1], s}) + BIAS) >>> SHIFT;
        if (t[AW])          return '0;
        else if (t > PMAX)  return '1;
        else                return t[DW-1:0];
    endfunction

    logic [DW-1:0]          win_p0  [0:K-1][0:K-1];
    logic signed [CW-1:0]   coef_shadow [0:NT-1];
    logic signed [CW-1:0]   coef_act    [0:NT-1];
    logic signed [PW-1:0]   prod_c  [0:NT-1];
    logic signed [AW-1:0]   tree_p  [0:LG][0:NT];
    logic [LAT-1:0]         vld_p;
    logic [LAT-1:0]         done_p;
    logic                   commit_ok;

    // Bank swap waits until no valid sample sits in the product or tree registers.
    assign commit_ok  = coef_pending & ~i_valid & ~(|vld_p[LG+1:1]);
    assign o_valid    = vld_p[LAT-1];
    assign o_img_done = done_p[LAT-1];

    // Valid and end-of-image flags travel in lockstep with the data pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p  <= '0;
            done_p <= '0;
        end else begin
            vld_p  <= {vld_p[LAT-2:0], i_valid};
            done_p <= {done_p[LAT-2:0], i_valid & i_done};
        end
    end

    // Shadow writes, deferred shadow-to-active copy and the pending flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NT; i++) begin
                coef_shadow[i] <= (i == CT) ? C_ID : '0;
                coef_act[i]    <= (i == CT) ? C_ID : '0;
            end
            coef_pending <= 1'b0;
        end else begin
            if (commit_ok)
                coef_act <= coef_shadow;
            if (coef_we && (int'(coef_addr) < NT))
                coef_shadow[coef_addr] <= coef_data;
            if (commit_ok)
                coef_pending <= 1'b0;
            else if (coef_commit)
                coef_pending <= 1'b1;
        end
    end

    // Stage 0: window shifts one column per valid input, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    win_p0[r][c] <= '0;
        end else if (i_valid) begin
            for (int r = 0; r < K; r++) begin
                win_p0[r][0] <= i_data[r*DW +: DW];
                for (int c = 1; c < K; c++)
                    win_p0[r][c] <= win_p0[r][c-1];
            end
        end
    end

    // Tap products: pixel zero-extended, coefficient sign-extended, full precision.
    always_comb begin
        prod_c = '{default: '0};
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                prod_c[r*K+c] = $signed({{(CW+1){1'b0}}, win_p0[r][c]})
                              * $signed({{(DW+1){coef_act[r*K+c][CW-1]}}, coef_act[r*K+c]});
    end

    // Stage 1 product registers (level 0) and one adder-tree level per cycle;
    // an unpaired trailing operand is registered through unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l <= LG; l++)
                for (int i = 0; i <= NT; i++)
                    tree_p[l][i] <= '0;
        end else begin
            for (int i = 0; i < NT; i++)
                tree_p[0][i] <= {{(AW-PW){prod_c[i][PW-1]}}, prod_c[i]};
            tree_p[0][NT] <= '0;
            for (int l = 1; l <= LG; l++) begin
                for (int i = 0; i < HALF; i++) begin
                    if (2*i + 1 < lvl_cnt(l - 1))
                        tree_p[l][i] <= tree_p[l-1][2*i] + tree_p[l-1][2*i+1];
                    else
                        tree_p[l][i] <= tree_p[l-1][2*i];
                end
                for (int i = HALF; i <= NT; i++)
                    tree_p[l][i] <= '0;
            end
        end
    end

    // Output stage: capture full sum and saturated pixel, hold between valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_data <= '0;
            o_pix  <= '0;
        end else if (vld_p[LG+1]) begin
            o_data <= tree_p[LG][0];
            o_pix  <= round_sat(tree_p[LG][0]);
        end
    end

endmodule

// File: tb/tb_conv_kxk_param.sv
// Bench for conv_kxk_param: a stimulus process drives columns and coefficient
// traffic while a behavioural model pushes expected outputs into a queue; a
// monitor pops and compares whenever the DUT presents o_valid.
module tb_conv_kxk_param;

    localparam int K     = 3;
    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int SHIFT = 0;
    localparam int NT    = K * K;
    localparam int LG    = $clog2(NT);
    localparam int AW    = DW + CW + 1 + LG;
    localparam int LAT   = 3 + LG;
    localparam int CT    = ((K - 1) / 2) * K + (K - 1) / 2;

    logic                  clk;
    logic                  reset;
    logic                  i_valid;
    logic                  i_done;
    logic [K*DW-1:0]       i_data;
    logic                  coef_we;
    logic [LG-1:0]         coef_addr;
    logic signed [CW-1:0]  coef_data;
    logic                  coef_commit;
    logic                  coef_pending;
    logic                  o_valid;
    logic                  o_img_done;
    logic signed [AW-1:0]  o_data;
    logic [DW-1:0]         o_pix;

    conv_kxk_param #(.K(K), .DW(DW), .CW(CW), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_done(i_done),
        .i_data(i_data), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_commit(coef_commit),
        .coef_pending(coef_pending), .o_valid(o_valid),
        .o_img_done(o_img_done), .o_data(o_data), .o_pix(o_pix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint d;
        longint p;
        bit     dn;
        int     c;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    bit     mon_en = 0;
    bit     started = 0;
    bit     prev_rst = 1;
    longint last_d, last_p;
    exp_t   e;

    // Reference state: window as rows x columns (column 0 newest), both banks,
    // pending flag, and the per-cycle history of accepted inputs.
    int m_win [K][K];
    int m_act [NT];
    int m_shd [NT];
    bit m_pend;
    bit vhist [int];

    function automatic void chk(input string nm, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, want, cyc);
        end
    endfunction

    function automatic longint exp_pix(input longint s);
        longint t;
        t = s + ((SHIFT > 0) ? (longint'(1) <<< (SHIFT > 0 ? SHIFT - 1 : 0)) : 0);
        t = t >>> SHIFT;
        if (t < 0) return 0;
        if (t > (2**DW - 1)) return 2**DW - 1;
        return t;
    endfunction

    function automatic logic [K*DW-1:0] mkcol(input int a0, input int a1, input int a2);
        logic [DW-1:0] b0, b1, b2;
        b0 = a0[DW-1:0];
        b1 = a1[DW-1:0];
        b2 = a2[DW-1:0];
        return {b2, b1, b0};
    endfunction

    function automatic logic [K*DW-1:0] rndcol();
        logic [31:0] rv;
        rv = $urandom;
        return rv[K*DW-1:0];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                m_win[r][c] = 0;
        for (int i = 0; i < NT; i++) begin
            m_act[i] = (i == CT) ? (1 << SHIFT) : 0;
            m_shd[i] = m_act[i];
        end
        m_pend = 0;
        vhist.delete();
        sb.delete();
    endtask

    // One clock cycle: drive inputs, advance the model across the coming edge.
    task automatic step(input bit iv, input bit id, input logic [K*DW-1:0] d,
                        input bit we, input int addr, input int cdata,
                        input bit commit, input bit rst);
        int c;
        bit blocked, apply;
        longint s;
        logic signed [CW-1:0] cv;
        exp_t x;
        i_valid     = iv;
        i_done      = id;
        i_data      = d;
        coef_we     = we;
        coef_addr   = addr[LG-1:0];
        coef_data   = cdata[CW-1:0];
        coef_commit = commit;
        reset       = rst;
        if (started) chk("coef_pending", coef_pending, m_pend);
        c = cyc;
        if (rst) begin
            model_reset();
        end else begin
            blocked = 0;
            for (int k = c - 2 - LG; k <= c - 2; k++)
                if (vhist.exists(k) && vhist[k]) blocked = 1;
            apply = m_pend && !iv && !blocked;
            if (iv) begin
                for (int r = 0; r < K; r++) begin
                    for (int cc = K - 1; cc > 0; cc--) m_win[r][cc] = m_win[r][cc-1];
                    m_win[r][0] = int'(d[r*DW +: DW]);
                end
                s = 0;
                for (int r = 0; r < K; r++)
                    for (int cc = 0; cc < K; cc++)
                        s += longint'(m_act[r*K+cc]) * longint'(m_win[r][cc]);
                x.d = s; x.p = exp_pix(s); x.dn = id; x.c = c;
                sb.push_back(x);
            end
            if (apply) m_act = m_shd;
            if (we && addr < NT) begin
                cv = cdata[CW-1:0];
                m_shd[addr] = int'(cv);
            end
            m_pend = apply ? 1'b0 : (commit ? 1'b1 : m_pend);
            vhist[c] = iv;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int addr, input int v);
        step(0, 0, '0, 1, addr, v, 0, 0);
    endtask

    // Monitor: pops the scoreboard on every o_valid; between valids the
    // outputs must hold and o_img_done must stay low.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_rst) begin
                last_d = 0;
                last_p = 0;
            end
            if (o_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got o_valid=1 want no output (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("o_data", longint'(o_data), e.d);
                    chk("o_pix", longint'(o_pix), e.p);
                    chk("o_img_done", longint'(o_img_done), longint'(e.dn));
                    chk("latency", longint'(cyc - e.c), LAT);
                end
                last_d = longint'(o_data);
                last_p = longint'(o_pix);
            end else begin
                chk("hold_o_data", longint'(o_data), last_d);
                chk("hold_o_pix", longint'(o_pix), last_p);
                chk("idle_img_done", longint'(o_img_done), 0);
            end
        end
        prev_rst = reset;
    end

    initial begin
        i_valid = 0; i_done = 0; i_data = '0; coef_we = 0; coef_addr = '0;
        coef_data = '0; coef_commit = 0; reset = 1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        chk("rst_o_valid", longint'(o_valid), 0);
        chk("rst_o_img_done", longint'(o_img_done), 0);
        chk("rst_o_data", longint'(o_data), 0);
        chk("rst_o_pix", longint'(o_pix), 0);
        chk("rst_coef_pending", longint'(coef_pending), 0);
        started = 1;
        mon_en = 1;

        // Identity kernel: output tracks the centre pixel.
        for (int col = 0; col < 12; col++)
            step(1, col == 11, mkcol(10*col, 10*col + 1, 10*col + 2), 0, 0, 0, 0, 0);
        idle(10);
        chk("identity_last_pix", longint'(o_pix), 10*10 + 1);

        // Sharpen kernel; a write landing on the swap cycle stays in the shadow.
        for (int t = 0; t < NT; t++) wr(t, (t == 4) ? 9 : -1);
        step(0, 0, '0, 0, 0, 0, 1, 0);
        wr(0, 7);
        idle(3);
        for (int i = 0; i < 5; i++) step(1, 0, mkcol(100, 100, 100), 0, 0, 0, 0, 0);
        idle(10);
        chk("flat_o_data", longint'(o_data), 100);
        chk("flat_o_pix", longint'(o_pix), 100);

        // Saturation high then low.
        step(1, 0, mkcol(0, 0, 0), 0, 0, 0, 0, 0);
        step(1, 0, mkcol(0, 255, 0), 0, 0, 0, 0, 0);
        step(1, 0, mkcol(0, 0, 0), 0, 0, 0, 0, 0);
        idle(10);
        chk("sat_hi_o_data", longint'(o_data), 2295);
        chk("sat_hi_o_pix", longint'(o_pix), 255);
        step(1, 0, mkcol(255, 255, 255), 0, 0, 0, 0, 0);
        step(1, 0, mkcol(255, 0, 255), 0, 0, 0, 0, 0);
        step(1, 0, mkcol(255, 255, 255), 0, 0, 0, 0, 0);
        idle(10);
        chk("sat_lo_o_data", longint'(o_data), -2040);
        chk("sat_lo_o_pix", longint'(o_pix), 0);

        // Deferred commit: requested mid-stream, repeated while pending.
        for (int t = 0; t < NT; t++) wr(t, int'($urandom_range(0, 400)) - 200);
        for (int i = 0; i < 12; i++)
            step(1, 0, rndcol(), 0, 0, 0, (i == 3) || (i == 6), 0);
        chk("pend_during_stream", longint'(coef_pending), 1);
        idle(12);
        chk("pend_cleared", longint'(coef_pending), 0);
        for (int i = 0; i < 6; i++) step(1, 0, rndcol(), 0, 0, 0, 0, 0);
        idle(10);

        // Valid gaps; i_done on an idle cycle must be ignored.
        step(1, 0, rndcol(), 0, 0, 0, 0, 0);
        step(0, 1, rndcol(), 0, 0, 0, 0, 0);
        step(0, 0, rndcol(), 0, 0, 0, 0, 0);
        step(1, 0, rndcol(), 0, 0, 0, 0, 0);
        step(1, 0, rndcol(), 0, 0, 0, 0, 0);
        step(0, 0, rndcol(), 0, 0, 0, 0, 0);
        step(1, 1, rndcol(), 0, 0, 0, 0, 0);
        idle(10);

        // Mid-stream reset: in-flight samples vanish, banks return to identity.
        for (int t = 0; t < NT; t++) wr(t, int'($urandom_range(0, 60)) - 30);
        step(0, 0, '0, 0, 0, 0, 1, 0);
        idle(4);
        for (int i = 0; i < 3; i++) step(1, 0, rndcol(), 0, 0, 0, 0, 0);
        step(0, 0, '0, 0, 0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 0, 0, 1);
        chk("post_rst_valid", longint'(o_valid), 0);
        for (int col = 0; col < 6; col++)
            step(1, col == 5, mkcol(3*col, 3*col + 1, 3*col + 2), 0, 0, 0, 0, 0);
        idle(10);
        chk("post_rst_identity_pix", longint'(o_pix), 3*4 + 1);

        // Randomised traffic, including out-of-range addresses and commits.
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, ($urandom % 8) == 0, rndcol(),
                 ($urandom % 3) == 0, int'($urandom_range(0, 15)), int'($urandom),
                 ($urandom % 20) == 0, 0);
        idle(20);
        chk("scoreboard_empty", longint'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_kxk_param.md
CONV_KXK_PARAM -- requirements
Module: conv_kxk_param

Interface
REQ-001 Parameter K, default 3: kernel size; odd, 3..7.
REQ-002 Parameter DW, default 8: unsigned pixel width.
REQ-003 Parameter CW, default 16: signed coefficient width.
REQ-004 Parameter SHIFT, default 0: right-shift applied before o_pix rounding; 0..CW-1.
REQ-005 Derived constants:
- NT = K*K.
- AW = DW+CW+1+clog2(NT).
- LAT = 3+clog2(NT).
REQ-006 Port clk, input, 1: clock; all logic rising-edge.
REQ-007 Port reset, input, 1: reset, synchronous, active-high; clock clk.
REQ-008 Port i_valid, input, 1: i_data column is valid this cycle.
REQ-009 Port i_done, input, 1: last column of image; qualified by i_valid.
REQ-010 Port i_data, input, K*DW: one column of K unsigned pixels; row r at bits [r*DW +: DW].
REQ-011 Port coef_we, input, 1: write coef_data into shadow bank at coef_addr.
REQ-012 Port coef_addr, input, clog2(NT): tap index r*K+c.
REQ-013 Port coef_data, input, CW: signed coefficient.
REQ-014 Port coef_commit, input, 1: request shadow-to-active bank copy.
REQ-015 Port coef_pending, output, 1: commit requested, not yet applied.
REQ-016 Port o_valid, output, 1: o_data/o_pix valid.
REQ-017 Port o_img_done, output, 1: delayed i_done, aligned with o_valid.
REQ-018 Port o_data, output, AW: signed full-precision sum.
REQ-019 Port o_pix, output, DW: rounded, shifted, saturated unsigned pixel.

Function
REQ-020 Window shall be a K x K register array; on i_valid=1, column 0 loads i_data and column c loads column c-1; with i_valid=0 the window shall hold.
REQ-021 The sum shall be Σ coef_active[r*K+c] * window[r][c]; pixels zero-extended to DW+1 signed; products DW+CW+1 bits; sign-extended to AW; no overflow possible.
REQ-022 The pipeline shall have four parts:
- window (1 cycle);
- registered multipliers (1 cycle);
- registered binary adder tree (clog2(NT) levels, one per cycle; odd operand passed through a register);
- round/saturate register (1 cycle).
REQ-023 o_valid shall equal i_valid delayed exactly LAT cycles; o_img_done shall equal (i_valid & i_done) delayed LAT cycles.
REQ-024 o_data/o_pix on an o_valid cycle shall reflect the window state after the corresponding i_valid shift, using the coefficient bank active on that shift cycle.
REQ-025 o_pix shall be computed as follows:
- t = (o_data + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (arithmetic);
- t < 0 gives 0;
- t > 2^DW-1 gives 2^DW-1;
- otherwise o_pix = t.
REQ-026 Shadow bank writes shall take effect the cycle after coef_we; an out-of-range coef_addr (>= NT) shall be ignored.
REQ-027 Commit control: coef_commit=1 shall set coef_pending on the next cycle.
REQ-028 Commit shall apply in the first cycle in which coef_pending=1, i_valid=0, and no valid sample occupies multiplier or adder stages; active bank = shadow; coef_pending clears the same edge.
REQ-029 Commit with simultaneous coef_we: the coef_we write shall land in the shadow bank only and not be copied in that commit.
REQ-030 coef_commit asserted while pending shall be absorbed, not queued twice.
REQ-031 Window contents between images shall not be cleared; the user shall flush or accept edge mixing.
REQ-032 o_data and o_pix shall hold their last values when o_valid=0.

Reset
REQ-033 On reset the following shall be cleared:
- window, pipeline data, all valid/done stages;
- o_valid, o_img_done, o_data, o_pix, coef_pending;
- all pending commits.
REQ-034 On reset both banks shall load identity: tap ((K-1)/2)*K+(K-1)/2 = 2^SHIFT, all others 0.
REQ-035 Reset mid-operation shall drop all in-flight samples; no o_valid shall follow until LAT cycles after the next post-reset i_valid.

Verification
REQ-036 Identity check:
- Setup: K=3, DW=8, reset.
- Stimulus: stream columns with row r = 10*col+r.
- Required: o_pix equals centre pixel (row 1, column col-1); first o_valid 7 cycles after first i_valid; o_data = o_pix.
REQ-037 Sharpen, flat field:
- Setup: write -1 to all taps, 9 to tap 4; commit.
- Stimulus: flat 100 field.
- Required: o_data=100, o_pix=100.
REQ-038 Saturation:
- Setup: sharpen kernel.
- Stimulus: centre 255, all others 0.
- Required: o_data=2295, o_pix=255.
- Stimulus: centre 0, all others 255.
- Required: o_data=-2040, o_pix=0.
REQ-039 Deferred commit:
- Stimulus: commit during continuous i_valid.
- Required: coef_pending stays 1 until i_valid low and pipeline drained, then clears; outputs before the switch use the old kernel, after it the new kernel.
REQ-040 Valid gaps:
- Stimulus: i_valid toggling 1,0,0,1 with i_done on the last column.
- Required: output sequence identical to gapless stream; o_img_done coincides with the last o_valid.
REQ-041 Mid-stream reset:
- Stimulus: reset asserted 3 cycles into a stream.
- Required: o_valid never asserts for pre-reset samples; coefficients return to identity.
